// File: rtl/updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter:
// mode encodings and the range clamp used by both load and saturate paths.
package updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Clamp a value into [min_v, max_v]; wide signed arithmetic so callers can
  // pass out-of-range intermediate sums or differences unchanged.
  function automatic longint clamp_range(input longint value,
                                         input longint min_v,
                                         input longint max_v);
    if (value < min_v) return min_v;
    if (value > max_v) return max_v;
    return value;
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count calculation for one step of the counter.
// Computes count +/- STEP in WIDTH+2 signed bits so neither the sum nor the
// difference can overflow, then either wraps by the range or clamps.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MIN_VAL  = 0,
  parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1,
  parameter longint STEP     = 1,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             sat_evt
);

  localparam int XW = WIDTH + 2;
  typedef logic signed [XW-1:0] ext_t;

  localparam ext_t MIN_X   = ext_t'(MIN_VAL);
  localparam ext_t MAX_X   = ext_t'(MAX_VAL);
  localparam ext_t STEP_X  = ext_t'(STEP);
  localparam ext_t RANGE_X = ext_t'(MAX_VAL - MIN_VAL + 1);

  ext_t count_x;
  ext_t stepped;
  ext_t wrapped;

  // Step once, then fold an out-of-range result back by wrapping or clamping.
  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    sat_evt    = 1'b0;
    count_x    = ext_t'({2'b00, count});
    stepped    = up_down ? (count_x + STEP_X) : (count_x - STEP_X);
    wrapped    = up_down ? (stepped - RANGE_X) : (stepped + RANGE_X);
    if ((stepped > MAX_X) || (stepped < MIN_X)) begin
      if (SATURATE == MODE_SAT) begin
        next_count = WIDTH'(clamp_range(longint'(stepped), MIN_VAL, MAX_VAL));
        sat_evt    = 1'b1;
      end else begin
        next_count = WIDTH'(wrapped);
        wrap_evt   = 1'b1;
      end
    end else begin
      next_count = WIDTH'(stepped);
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with configurable width, range, step and
// wrap/saturate mode; enable, clear and parallel load with priority
// reset > clear > load > en. Terminal flags are combinational; wrap/sat are
// registered one-cycle pulses.
// Optional feature macro: UPDOWN_COUNTER_STICKY_OVF_EN builds a sticky flag
// that records any wrap or saturate event until reset or clear. Without it
// sticky_ovf is tied low and no register exists.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint MIN_VAL   = 0,
  parameter longint MAX_VAL   = (longint'(1) << WIDTH) - 1,
  parameter longint STEP      = 1,
  parameter int     SATURATE  = MODE_WRAP,
  parameter longint RESET_VAL = MIN_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat,
  output logic             sticky_ovf
);

  // Parameter legality, checked at elaboration.
  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 2..32");
  end
  if (MIN_VAL >= MAX_VAL) begin : g_bad_range
    $error("updown_counter_param: MIN_VAL must be below MAX_VAL");
  end
  if ((MIN_VAL < 0) || (MAX_VAL > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
    $error("updown_counter_param: range does not fit in WIDTH bits");
  end
  if ((STEP < 1) || (STEP > (MAX_VAL - MIN_VAL + 1))) begin : g_bad_step
    $error("updown_counter_param: STEP must be in 1..range");
  end
  if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
    $error("updown_counter_param: SATURATE must be 0 or 1");
  end
  if ((RESET_VAL < MIN_VAL) || (RESET_VAL > MAX_VAL)) begin : g_bad_reset
    $error("updown_counter_param: RESET_VAL outside [MIN_VAL, MAX_VAL]");
  end

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             sat_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             sat_d;
  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             sat_evt;

  updown_counter_next #(
    .WIDTH    (WIDTH),
    .MIN_VAL  (MIN_VAL),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .count      (count_q),
    .up_down    (up_down),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .sat_evt    (sat_evt)
  );

  // Priority mux below reset: clear, then load, then counting.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (clear) begin
      count_d = RESET_W;
    end else if (load) begin
      count_d = WIDTH'(clamp_range(longint'(load_val), MIN_VAL, MAX_VAL));
    end else if (en) begin
      count_d = next_count;
      wrap_d  = wrap_evt;
      sat_d   = sat_evt;
    end
  end

  // Count and event-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_W;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
  logic sticky_q;

  // Remember any wrap or saturate event; only reset or clear forget it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sticky_q <= 1'b0;
    end else if (wrap_d || sat_d) begin
      sticky_q <= 1'b1;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  assign sticky_ovf = 1'b0;
`endif

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign sat    = sat_q;
  assign at_max = (count_q == MAX_W);
  assign at_min = (count_q == MIN_W);

endmodule
